// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus types, cache geometry, FSM states.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W    = 32;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned ICACHE_INDEX_W = 6;
  localparam int unsigned ICACHE_TAG_W   = INST_ADDR_W - ICACHE_INDEX_W - 2;
  localparam int unsigned ICACHE_LINES   = 1 << ICACHE_INDEX_W;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StMiss  = 2'd1,
    StDrop  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
module if_stage_icache
  import if_stage_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  inst_addr_t lookup_addr_i,
  output logic       hit_o,
  output inst_t      data_o,
  input  logic       fill_we_i,
  input  inst_addr_t fill_addr_i,
  input  inst_t      fill_data_i
);

  logic [ICACHE_LINES-1:0] valid_q, valid_d;
  logic [ICACHE_TAG_W-1:0] tag_q [ICACHE_LINES];
  inst_t                   data_q [ICACHE_LINES];

  logic [ICACHE_INDEX_W-1:0] lookup_idx, fill_idx;
  logic [ICACHE_TAG_W-1:0]   lookup_tag, fill_tag;
  logic                      unused_offset;

  assign lookup_idx    = lookup_addr_i[ICACHE_INDEX_W+1:2];
  assign lookup_tag    = lookup_addr_i[INST_ADDR_W-1:ICACHE_INDEX_W+2];
  assign fill_idx      = fill_addr_i[ICACHE_INDEX_W+1:2];
  assign fill_tag      = fill_addr_i[INST_ADDR_W-1:ICACHE_INDEX_W+2];
  // Instructions are word aligned; the byte offset never selects anything.
  assign unused_offset = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

  assign hit_o  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign data_o = data_q[lookup_idx];

  always_comb begin
    valid_d = valid_q;
    if (fill_we_i) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data need no reset: they are only read behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, I-cache lookup, miss handling via req/ack, registered IF/ID outputs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_flag_in,
  input  logic [31:0] branch_target_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  if_state_e  state_q, state_d;
  inst_addr_t pc_q, pc_d;
  inst_addr_t pc_out_q, pc_out_d;
  inst_t      inst_out_q, inst_out_d;
  logic       valid_q, valid_d;
  logic       mem_req_q, mem_req_d;
  inst_addr_t mem_addr_q, mem_addr_d;

  logic  cache_hit;
  inst_t cache_data;
  logic  fill_we;

  if_stage_icache u_icache (
    .clk_i         (clk),
    .rst_i         (rst),
    .lookup_addr_i (pc_q),
    .hit_o         (cache_hit),
    .data_o        (cache_data),
    .fill_we_i     (fill_we),
    .fill_addr_i   (mem_addr_q),
    .fill_data_i   (mem_inst_in)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    inst_out_d = inst_out_q;
    valid_d    = valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (branch_flag_in) begin
          pc_d    = branch_target_in;
          valid_d = 1'b0;
        end else if (!stall_in) begin
          if (cache_hit) begin
            inst_out_d = cache_data;
            pc_out_d   = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            valid_d    = 1'b0;
            state_d    = StMiss;
          end
        end
      end
      StMiss: begin
        if (mem_ack_in) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StFetch;
          if (branch_flag_in) begin
            pc_d = branch_target_in;
          end else if (!stall_in) begin
            inst_out_d = mem_inst_in;
            pc_out_d   = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end else if (branch_flag_in) begin
          pc_d    = branch_target_in;
          state_d = StDrop;
        end
      end
      StDrop: begin
        // The controller cannot abort, so wait out the ack and keep only the fill.
        if (branch_flag_in) begin
          pc_d = branch_target_in;
        end
        if (mem_ack_in) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      inst_out_q <= '0;
      valid_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      inst_out_q <= inst_out_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;
  assign pc_out       = pc_out_q;
  assign inst_out     = inst_out_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, checked against a behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        branch_flag_in;
  logic [31:0] branch_target_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_inst_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .branch_flag_in   (branch_flag_in),
    .branch_target_in (branch_target_in),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_ack_in       (mem_ack_in),
    .mem_inst_in      (mem_inst_in),
    .pc_out           (pc_out),
    .inst_out         (inst_out),
    .valid_out        (valid_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the cache is a table of remembered word addresses, one slot per index.
  bit [31:0] m_line_addr [64];
  bit [31:0] m_line_data [64];
  bit        m_line_ok   [64];
  bit [31:0] m_pc, m_pc_out, m_inst, m_addr;
  bit        m_valid, m_req, m_discard;

  function automatic int slot(input bit [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_line_ok[i] = 1'b0;
    m_pc = 32'h0; m_pc_out = 32'h0; m_inst = 32'h0; m_addr = 32'h0;
    m_valid = 1'b0; m_req = 1'b0; m_discard = 1'b0;
  endtask

  task automatic present(input bit [31:0] word);
    m_inst   = word;
    m_pc_out = m_pc;
    m_valid  = 1'b1;
    m_pc     = m_pc + 32'd4;
  endtask

  task automatic model_step(input bit s, input bit b, input bit [31:0] t, input bit a,
                            input bit [31:0] d);
    if (!m_req) begin
      if (b) begin
        m_pc = t; m_valid = 1'b0;
      end else if (!s) begin
        if (m_line_ok[slot(m_pc)] && m_line_addr[slot(m_pc)] == m_pc) begin
          present(m_line_data[slot(m_pc)]);
        end else begin
          m_req = 1'b1; m_addr = m_pc; m_valid = 1'b0; m_discard = 1'b0;
        end
      end
    end else begin
      if (a) begin
        m_line_ok[slot(m_addr)]   = 1'b1;
        m_line_addr[slot(m_addr)] = m_addr;
        m_line_data[slot(m_addr)] = d;
        m_req = 1'b0;
        if (!m_discard && !b && !s) present(d);
      end
      if (b) begin
        m_pc = t;
        if (!a) m_discard = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_model();
    chk("req", {31'h0, mem_req_out}, {31'h0, m_req});
    chk("valid", {31'h0, valid_out}, {31'h0, m_valid});
    if (m_req) chk("addr", mem_addr_out, m_addr);
    if (m_valid) begin
      chk("pc_out", pc_out, m_pc_out);
      chk("inst_out", inst_out, m_inst);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check 1 time unit later.
  task automatic cycle(input bit s, input bit b, input bit [31:0] t, input bit a,
                       input bit [31:0] d);
    stall_in = s; branch_flag_in = b; branch_target_in = t; mem_ack_in = a; mem_inst_in = d;
    @(posedge clk);
    model_step(s, b, t, a, d);
    #1;
    chk_model();
    branch_flag_in = 1'b0;
    mem_ack_in     = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic ack(input bit [31:0] d);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, d);
  endtask

  task automatic branch(input bit [31:0] t);
    cycle(1'b0, 1'b1, t, 1'b0, 32'h0);
  endtask

  initial begin
    bit        s, b, a;
    bit [31:0] t, d;
    rst = 1'b1; stall_in = 1'b0; branch_flag_in = 1'b0; branch_target_in = '0;
    mem_ack_in = 1'b0; mem_inst_in = '0;
    model_reset();
    #7;
    chk("rst_req", {31'h0, mem_req_out}, 32'h0);
    chk("rst_addr", mem_addr_out, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold start: three sequential misses.
    idle();
    chk("cold_req", {31'h0, mem_req_out}, 32'h1);
    chk("cold_addr", mem_addr_out, 32'h0);
    ack(32'h0000_0013);
    chk("cold_inst", inst_out, 32'h0000_0013);
    idle();
    chk("cold_next_addr", mem_addr_out, 32'h4);
    idle();
    ack(32'h0010_0093);
    idle();
    ack(32'h0020_0113);
    chk("cold_pc8", pc_out, 32'h8);

    // Hit path after redirect to 0.
    branch(32'h0);
    chk("redir_valid", {31'h0, valid_out}, 32'h0);
    idle(); chk("hit_pc0", pc_out, 32'h0);
    idle(); chk("hit_pc4", pc_out, 32'h4);
    idle(); chk("hit_pc8", pc_out, 32'h8);
    chk("hit_noreq", {31'h0, mem_req_out}, 32'h0);

    // Stall holds outputs.
    branch(32'h0);
    idle(); idle();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_pc", pc_out, 32'h4);
    chk("stall_inst", inst_out, 32'h0010_0093);
    idle();
    chk("stall_release", pc_out, 32'h8);

    // Branch while a miss is in flight: fill kept, data dropped.
    idle();
    chk("drop_addr", mem_addr_out, 32'hC);
    branch(32'h100);
    idle();
    ack(32'hDEAD_BEEF);
    chk("drop_valid", {31'h0, valid_out}, 32'h0);
    idle();
    chk("drop_next_addr", mem_addr_out, 32'h100);
    ack(32'h1111_1111);
    chk("alias_pc", pc_out, 32'h100);
    branch(32'hC);
    idle();
    chk("drop_fill_inst", inst_out, 32'hDEAD_BEEF);
    branch(32'h0);
    idle();
    chk("alias_refetch", {31'h0, mem_req_out}, 32'h1);
    ack(32'h0000_0013);

    // PC wraps past the top of the address space.
    branch(32'hFFFF_FFFC);
    idle();
    ack(32'h0000_0055);
    idle();
    chk("wrap_pc", pc_out, 32'h0);

    // Reset in the middle of a miss.
    branch(32'h40);
    idle();
    chk("mid_req", {31'h0, mem_req_out}, 32'h1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_req", {31'h0, mem_req_out}, 32'h0);
    chk("mid_rst_valid", {31'h0, valid_out}, 32'h0);
    chk("mid_rst_pc", pc_out, 32'h0);
    #3 rst = 1'b0;
    idle();
    chk("post_rst_miss", {31'h0, mem_req_out}, 32'h1);
    chk("post_rst_addr", mem_addr_out, 32'h0);

    // Random traffic; acks only while a request is outstanding.
    for (int i = 0; i < 800; i++) begin
      s = ($urandom % 5) == 0;
      b = ($urandom % 10) == 0;
      t = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
      a = m_req && (($urandom % 3) == 0);
      d = $urandom;
      cycle(s, b, t, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
